// File: rtl/alu_muldiv_pkg.sv
// Shared ALU definitions: operand width, AluOp encoding, mul/div FSM state codes
// and the magnitude helper used by the iterative engine.
package alu_muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);

    typedef logic [WIDTH-1:0] word_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_LUI  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_MFHI = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // 0x80000000 maps to itself, which is the correct magnitude when read unsigned.
    function automatic word_t mag(input word_t v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply/divide engine owning the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for Start with ALUOp Mul/Div
// CALC  | one shift-add / restoring shift-subtract step per cycle
// FIX   | sign correction, HI/LO written at end of cycle
// DONE  | Done pulse (with DivByZero when divisor was 0)
module muldiv_iter
    import alu_muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   p_hi, p_lo, mcand;
    logic               is_div, neg_main, neg_rem, dz;
    logic               launch;
    logic [WIDTH:0]     mul_sum, div_shl, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo, quo, rem, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    assign launch = start && (op == OP_MUL || op == OP_DIV);

    // {p_hi,p_lo} is the product accumulator for mul, and {remainder,quotient} for div.
    always_comb begin
        mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        div_shl  = {p_hi, p_lo[WIDTH-1]};
        div_diff = div_shl - {1'b0, mcand};
        if (is_div) begin
            if (div_diff[WIDTH]) begin
                step_hi = div_shl[WIDTH-1:0];
                step_lo = {p_lo[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {p_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
        end
        prod   = neg_main ? -{p_hi, p_lo} : {p_hi, p_lo};
        quo    = neg_main ? -p_lo : p_lo;
        rem    = neg_rem ? -p_hi : p_hi;
        fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        fix_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            mcand    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dz <= 1'b0;
                    if (launch) begin
                        if (op == OP_DIV && b == '0) begin
                            dz    <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            p_hi     <= '0;
                            p_lo     <= mag(a);
                            mcand    <= mag(b);
                            is_div   <= (op == OP_DIV);
                            neg_main <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_rem  <= a[WIDTH-1];
                            cnt      <= CNT_LOAD;
                            state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    p_hi <= step_hi;
                    p_lo <= step_lo;
                    if (cnt == '0) state <= ST_FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state == ST_CALC) || (state == ST_FIX);
    assign done        = (state == ST_DONE);
    assign div_by_zero = done && dz;

endmodule

// File: rtl/alu_muldiv.sv
// Datapath ALU: single-cycle ops, Result mux and Zero; signed MUL/DIV via muldiv_iter.
// Optional macro ALU_OVERFLOW_EN adds the signed add/sub Overflow output.
module alu_muldiv
    import alu_muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    input  logic             Start,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    logic [WIDTH-1:0] sum, diff;
    logic             lt;

    muldiv_iter u_muldiv (
        .clk         (clk),
        .reset       (reset),
        .op          (ALUOp),
        .a           (A),
        .b           (B),
        .start       (Start),
        .busy        (Busy),
        .done        (Done),
        .div_by_zero (DivByZero),
        .hi          (Hi),
        .lo          (Lo)
    );

    assign sum  = A + B;
    assign diff = A - B;
    assign lt   = $signed(A) < $signed(B);

    always_comb begin
        Result = sum;
        case (ALUOp)
            OP_ADD:  Result = sum;
            OP_SUB:  Result = diff;
            OP_OR:   Result = A | B;
            OP_SLL:  Result = B << Shamt;
            OP_SLT:  Result = {{(WIDTH-1){1'b0}}, lt};
            OP_LUI:  Result = {B[15:0], 16'h0000};
            OP_MFHI: Result = Hi;
            OP_MUL:  Result = Lo;
            OP_DIV:  Result = Lo;
            default: Result = sum;
        endcase
    end

    assign Zero = (Result == '0);

`ifdef ALU_OVERFLOW_EN
    assign Overflow = !reset &&
        ((ALUOp == OP_ADD && A[WIDTH-1] == B[WIDTH-1] && Result[WIDTH-1] != A[WIDTH-1]) ||
         (ALUOp == OP_SUB && A[WIDTH-1] != B[WIDTH-1] && Result[WIDTH-1] != A[WIDTH-1]));
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus queues expectations, a negedge monitor checks them.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_op;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        start;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done, dz;
`ifdef ALU_OVERFLOW_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    alu_muldiv dut (
        .clk       (clk),
        .reset     (reset),
        .ALUOp     (alu_op),
        .A         (a),
        .B         (b),
        .Shamt     (shamt),
        .Start     (start),
        .Result    (result),
        .Zero      (zero),
        .Busy      (busy),
        .Done      (done),
        .DivByZero (dz),
        .Hi        (hi),
        .Lo        (lo)
`ifdef ALU_OVERFLOW_EN
        ,
        .Overflow  (ovf)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        zero;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } comb_exp_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          busy_cycles;
        int          start_ref;
    } done_exp_t;

    comb_exp_t   comb_q[$];
    done_exp_t   done_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          comb_req = 0;
    int          comb_seen = 0;
    int          busy_run = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (comb_req != comb_seen) begin
            comb_seen++;
            if (comb_q.size() == 0) begin
                check("comb_queue_entries", 64'(comb_q.size()), 64'd1);
            end else begin
                comb_exp_t e;
                e = comb_q.pop_front();
                check({e.name, ".result"}, result, e.result);
                check({e.name, ".zero"},   zero,   e.zero);
                check({e.name, ".busy"},   busy,   e.busy);
                check({e.name, ".hi"},     hi,     e.hi);
                check({e.name, ".lo"},     lo,     e.lo);
`ifdef ALU_OVERFLOW_EN
                check({e.name, ".overflow"}, ovf, e.ovf);
`endif
            end
        end
        if (reset) busy_run = 0;
        else if (busy) busy_run++;
        if (done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                check({d.name, ".latency"},     64'(cyc - d.start_ref), 64'(d.lat));
                check({d.name, ".busy_cycles"}, 64'(busy_run), 64'(d.busy_cycles));
                check({d.name, ".hi"},          hi, d.hi);
                check({d.name, ".lo"},          lo, d.lo);
                check({d.name, ".div_by_zero"}, dz, d.dz);
            end
            busy_run = 0;
        end
    end

    // Entered and left just after a rising edge; the monitor samples at the negedge in between.
    task automatic comb(input string name, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic exp_ovf);
        comb_exp_t e;
        alu_op = op;
        a      = av;
        b      = bv;
        shamt  = sh;
        e.name   = name;
        e.result = exp_res;
        e.zero   = (exp_res == 32'h0);
        e.busy   = 1'b0;
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.ovf    = exp_ovf;
        comb_q.push_back(e);
        comb_req++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input bit push, input logic [31:0] eh,
                         input logic [31:0] el, input logic edz, input int lat, input int bc);
        done_exp_t d;
        alu_op = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        if (push) begin
            d.name        = name;
            d.hi          = eh;
            d.lo          = el;
            d.dz          = edz;
            d.lat         = lat;
            d.busy_cycles = bc;
            d.start_ref   = cyc;
            done_q.push_back(d);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check({name, ".done_timeout"}, done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        alu_op = OP_ADD;
        a      = 32'h0;
        b      = 32'h0;
        shamt  = 5'd0;
        start  = 1'b0;
        idle(3);
        reset = 1'b0;

        comb("reset_mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        comb("reset_lo",   OP_MUL,  32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        comb("sub_eq",     OP_SUB,  32'd5, 32'd5, 5'd0, 32'h0, 1'b0);
        comb("slt_neg",    OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
        comb("slt_pos",    OP_SLT,  32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
        comb("add",        OP_ADD,  32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
        comb("add_ovf",    OP_ADD,  32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1);
        comb("sub_ovf",    OP_SUB,  32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1);
        comb("sub_neg",    OP_SUB,  32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0);
        comb("or",         OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0);
        comb("sll31",      OP_SLL,  32'h0, 32'd3, 5'd31, 32'h8000_0000, 1'b0);
        comb("lui",        OP_LUI,  32'h0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 1'b0);
        comb("undef_op",   4'hF,    32'd10, 32'd20, 5'd0, 32'd30, 1'b0);

        issue("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 33);
        wait_done("mul_7_m3");
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFEB;
        comb("mfhi_after_mul", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        comb("lo_after_mul",   OP_MUL,  32'h0, 32'h0, 5'd0, 32'hFFFF_FFEB, 1'b0);

        issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 33);
        wait_done("div_m7_2");
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
        comb("lo_after_div", OP_DIV, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFD, 1'b0);

        issue("div_11_4", OP_DIV, 32'd11, 32'd4, 1'b1, 32'd3, 32'd2, 1'b0, 34, 33);
        wait_done("div_11_4");
        m_hi = 32'd3; m_lo = 32'd2;

        issue("div_by_zero", OP_DIV, 32'd5, 32'd0, 1'b1, 32'd3, 32'd2, 1'b1, 1, 0);
        wait_done("div_by_zero");
        comb("mfhi_after_div0", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'd3, 1'b0);

        issue("mul_3_4", OP_MUL, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0, 34, 33);
        idle(9);
        alu_op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        idle(1);
        start = 1'b0; alu_op = OP_MUL;
        wait_done("mul_3_4");
        m_hi = 32'd0; m_lo = 32'd12;
        idle(40);
        comb("lo_after_mul_3_4", OP_MUL, 32'h0, 32'h0, 5'd0, 32'd12, 1'b0);

        issue("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34, 33);
        wait_done("div_min_m1");
        m_hi = 32'd0; m_lo = 32'h8000_0000;
        comb("mfhi_after_min_div", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'd0, 1'b0);

        issue("add_start", OP_ADD, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0, 0, 0);
        idle(40);
        comb("add_after_ignored", OP_ADD, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);

        issue("mul_big", OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd1, 32'd0, 1'b0, 34, 33);
        wait_done("mul_big");
        m_hi = 32'd1; m_lo = 32'd0;
        comb("mfhi_after_big", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'd1, 1'b0);

        issue("mul_abort", OP_MUL, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 0, 0);
        idle(19);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        comb("mfhi_after_abort", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'd0, 1'b0);
        idle(40);
        comb("lo_after_abort", OP_MUL, 32'h0, 32'h0, 5'd0, 32'd0, 1'b0);

        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        check("comb_queue_drained", 64'(comb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
